// File: rtl/mvm_stream_banked_if.sv
// Ready/valid stream bundle for mvm_stream_banked: element input and result output.
interface mvm_stream_banked_if #(
  parameter int B  = 8,
  parameter int OW = 16
) ();
  logic                 s_valid;
  logic                 s_ready;
  logic signed [B-1:0]  s_data;
  logic                 m_valid;
  logic                 m_ready;
  logic signed [OW-1:0] m_data;
  logic                 m_last;

  modport slave  (input  s_valid, s_data, m_ready, output s_ready, m_valid, m_data, m_last);
  modport master (output s_valid, s_data, m_ready, input  s_ready, m_valid, m_data, m_last);
endinterface

// File: rtl/mvm_stream_banked.sv
// Streamed y = A*x for a persistent MxN signed matrix, P rows per group in parallel MAC lanes.
// Matrix rows are interleaved across P banks (row mod P) so each lane reads its own bank.
module mvm_stream_banked #(
  parameter int M   = 8,
  parameter int N   = 8,
  parameter int B   = 8,
  parameter int P   = 2,
  parameter int OW  = 16,
  parameter int SAT = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load_matrix,
  mvm_stream_banked_if.slave s,
  output logic               mat_loaded,
  output logic               err
);
  localparam int unsigned GRP   = M / P;
  localparam int unsigned DEPTH = GRP * N;
  localparam int unsigned ACC   = 2 * B + $clog2(N);
  localparam int unsigned PW    = 2 * B;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned XW    = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW    = $clog2(N + 1);
  localparam int unsigned GW    = (GRP > 1) ? $clog2(GRP) : 1;
  localparam int unsigned LW    = (P > 1) ? $clog2(P) : 1;
  localparam int unsigned W     = (ACC > OW) ? ACC : OW;
  localparam logic signed [W-1:0] SAT_MAX = {{(W-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [W-1:0] SAT_MIN = {{(W-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_X, S_COMPUTE, S_OUT} state_t;
  state_t r_state, w_state_nx;

  logic signed [B-1:0]   r_mem [P][DEPTH];
  logic signed [B-1:0]   r_x   [N];
  logic signed [B-1:0]   r_rd  [P];
  logic signed [B-1:0]   r_xrd;
  logic signed [ACC-1:0] r_acc [P];
  logic signed [PW-1:0]  w_prod [P];
  logic [XW-1:0] r_col;
  logic [LW-1:0] r_wbank, r_lane;
  logic [GW-1:0] r_wgrp, r_g;
  logic [CW-1:0] r_cyc;
  logic          r_mat_loaded, r_err;
  logic          w_s_fire, w_m_fire, w_col_last, w_a_last, w_grp_last, w_lane_last, w_cyc_last;
  logic          w_s_ready, w_m_valid, w_m_last;
  logic signed [OW-1:0] w_m_data, w_sat;
  logic signed [W-1:0]  w_ext;
  logic [AW-1:0] w_waddr, w_raddr;

  assign w_s_fire    = s.s_valid && w_s_ready;
  assign w_m_fire    = w_m_valid && s.m_ready;
  assign w_col_last  = (r_col == XW'(N - 1));
  assign w_a_last    = w_col_last && (r_wbank == LW'(P - 1)) && (r_wgrp == GW'(GRP - 1));
  assign w_grp_last  = (r_g == GW'(GRP - 1));
  assign w_lane_last = (r_lane == LW'(P - 1));
  assign w_cyc_last  = (r_cyc == CW'(N));
  assign w_waddr     = AW'(r_wgrp) * AW'(N) + AW'(r_col);
  assign w_raddr     = AW'(r_g) * AW'(N) + AW'(r_cyc);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:    if (load_matrix) w_state_nx = S_LOAD_A;
                 else if (r_mat_loaded) w_state_nx = S_LOAD_X;
      S_LOAD_A:  if (w_s_fire && w_a_last) w_state_nx = S_LOAD_X;
      S_LOAD_X:  if (load_matrix) w_state_nx = S_LOAD_A;
                 else if (w_s_fire && w_col_last) w_state_nx = S_COMPUTE;
      S_COMPUTE: if (w_cyc_last) w_state_nx = S_OUT;
      S_OUT:     if (w_m_fire && w_lane_last) w_state_nx = w_grp_last ? S_LOAD_X : S_COMPUTE;
      default:   w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_s_ready = (r_state == S_LOAD_A) || (r_state == S_LOAD_X);
    w_m_valid = (r_state == S_OUT);
    w_m_last  = w_m_valid && w_grp_last && w_lane_last;
    w_m_data  = w_m_valid ? w_sat : '0;
  end

  always_comb begin
    w_ext = W'(r_acc[r_lane]);
    if (SAT != 0 && w_ext > SAT_MAX)      w_sat = SAT_MAX[OW-1:0];
    else if (SAT != 0 && w_ext < SAT_MIN) w_sat = SAT_MIN[OW-1:0];
    else                                  w_sat = w_ext[OW-1:0];
  end

  always_comb begin
    for (int unsigned p = 0; p < P; p++) w_prod[p] = PW'(r_rd[p]) * PW'(r_xrd);
  end

  // Operand reads in COMPUTE cycle j land in r_rd/r_xrd and are accumulated one cycle later.
  always_ff @(posedge clk) begin
    if (r_state == S_LOAD_A && w_s_fire) begin
      for (int unsigned p = 0; p < P; p++)
        if (r_wbank == LW'(p)) r_mem[p][w_waddr] <= s.s_data;
    end
    if (r_state == S_LOAD_X && w_s_fire) r_x[r_col] <= s.s_data;
    if (r_state == S_COMPUTE && !w_cyc_last) begin
      for (int unsigned p = 0; p < P; p++) r_rd[p] <= r_mem[p][w_raddr];
      r_xrd <= r_x[XW'(r_cyc)];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_col        <= '0;
      r_wbank      <= '0;
      r_wgrp       <= '0;
      r_cyc        <= '0;
      r_g          <= '0;
      r_lane       <= '0;
      r_mat_loaded <= 1'b0;
      r_err        <= 1'b0;
      for (int unsigned p = 0; p < P; p++) r_acc[p] <= '0;
    end else begin
      if (load_matrix && (r_state == S_LOAD_A || r_state == S_COMPUTE || r_state == S_OUT))
        r_err <= 1'b1;
      case (r_state)
        S_IDLE, S_LOAD_X: begin
          if (load_matrix) begin
            r_col        <= '0;
            r_wbank      <= '0;
            r_wgrp       <= '0;
            r_mat_loaded <= 1'b0;
          end else if (r_state == S_LOAD_X && w_s_fire) begin
            r_col <= w_col_last ? '0 : r_col + 1'b1;
          end
        end
        S_LOAD_A: if (w_s_fire) begin
          r_col <= w_col_last ? '0 : r_col + 1'b1;
          if (w_col_last) begin
            r_wbank <= (r_wbank == LW'(P - 1)) ? '0 : r_wbank + 1'b1;
            if (r_wbank == LW'(P - 1)) r_wgrp <= (r_wgrp == GW'(GRP - 1)) ? '0 : r_wgrp + 1'b1;
          end
          if (w_a_last) r_mat_loaded <= 1'b1;
        end
        S_COMPUTE: begin
          r_cyc <= w_cyc_last ? '0 : r_cyc + 1'b1;
          for (int unsigned p = 0; p < P; p++)
            r_acc[p] <= (r_cyc == '0) ? '0 : r_acc[p] + ACC'(w_prod[p]);
        end
        S_OUT: if (w_m_fire) begin
          r_lane <= w_lane_last ? '0 : r_lane + 1'b1;
          if (w_lane_last) r_g <= w_grp_last ? '0 : r_g + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign s.s_ready  = w_s_ready;
  assign s.m_valid  = w_m_valid;
  assign s.m_data   = w_m_data;
  assign s.m_last   = w_m_last;
  assign mat_loaded = r_mat_loaded;
  assign err        = r_err;
endmodule

// File: tb/tb_mvm_stream_banked.sv
// Directed bench for mvm_stream_banked (M=N=4, P=2): a saturating and a wrapping instance share stimulus.
module tb_mvm_stream_banked;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, tb_load, tb_s_valid, tb_m_ready;
  logic signed [7:0] tb_s_data;
  logic mat_s, err_s, mat_w, err_w;
  int checks = 0;
  int errors = 0;
  int amat [16];
  int xv [4];
  int ys [4];
  int yw [4];

  mvm_stream_banked_if #(.B(8), .OW(16)) bus_s ();
  mvm_stream_banked_if #(.B(8), .OW(16)) bus_w ();

  assign bus_s.s_valid = tb_s_valid;
  assign bus_s.s_data  = tb_s_data;
  assign bus_s.m_ready = tb_m_ready;
  assign bus_w.s_valid = tb_s_valid;
  assign bus_w.s_data  = tb_s_data;
  assign bus_w.m_ready = tb_m_ready;

  mvm_stream_banked #(.M(4), .N(4), .B(8), .P(2), .OW(16), .SAT(1)) u_dut_s (
    .clk(clk), .reset_n(reset_n), .load_matrix(tb_load), .s(bus_s),
    .mat_loaded(mat_s), .err(err_s));
  mvm_stream_banked #(.M(4), .N(4), .B(8), .P(2), .OW(16), .SAT(0)) u_dut_w (
    .clk(clk), .reset_n(reset_n), .load_matrix(tb_load), .s(bus_w),
    .mat_loaded(mat_w), .err(err_w));

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_load();
    tb_load = 1'b1;
    @(posedge clk); #1;
    tb_load = 1'b0;
  endtask

  task automatic send_elem(input int v);
    int n;
    tb_s_valid = 1'b1;
    tb_s_data  = 8'(v);
    n = 0;
    while (bus_s.s_ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    chk("send_wait", 32'(n < 100), 1);
    @(posedge clk); #1;
    tb_s_valid = 1'b0;
  endtask

  task automatic send_A();
    for (int k = 0; k < 16; k++) send_elem(amat[k]);
  endtask

  task automatic send_x();
    for (int j = 0; j < 4; j++) send_elem(xv[j]);
  endtask

  task automatic set_exp(input int a, input int b, input int c, input int d);
    ys = '{a, b, c, d};
    yw = ys;
  endtask

  task automatic recv_vec(input string tag, input int first);
    int n;
    for (int i = first; i < 4; i++) begin
      tb_m_ready = 1'b1;
      n = 0;
      while (bus_s.m_valid !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
      chk($sformatf("%s_wait%0d", tag, i), 32'(n < 200), 1);
      chk($sformatf("%s_ysat%0d", tag, i), 32'(bus_s.m_data), ys[i]);
      chk($sformatf("%s_ywrap%0d", tag, i), 32'(bus_w.m_data), yw[i]);
      chk($sformatf("%s_last%0d", tag, i), 32'(bus_s.m_last), 32'(i == 3));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n, cnt;
    reset_n = 1'b0; tb_load = 1'b0; tb_s_valid = 1'b0; tb_s_data = '0; tb_m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", 32'(bus_s.s_ready), 0);
    chk("rst_m_valid", 32'(bus_s.m_valid), 0);
    chk("rst_m_last",  32'(bus_s.m_last), 0);
    chk("rst_m_data",  32'(bus_s.m_data), 0);
    chk("rst_mat",     32'(mat_s), 0);
    chk("rst_err",     32'(err_s), 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // no matrix: stream must be refused
    tb_s_valid = 1'b1; tb_s_data = 8'sd7; cnt = 0;
    repeat (20) begin
      if (bus_s.s_ready !== 1'b0) cnt++;
      @(posedge clk); #1;
    end
    tb_s_valid = 1'b0;
    chk("idle_no_ready", cnt, 0);

    // identity, latency
    for (int k = 0; k < 16; k++) amat[k] = (k % 5 == 0) ? 1 : 0;
    pulse_load(); send_A();
    chk("t1_mat_s", 32'(mat_s), 1);
    chk("t1_mat_w", 32'(mat_w), 1);
    xv = '{1, 2, 3, 4}; send_x();
    n = 0;
    while (bus_s.m_valid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    chk("t1_latency", n, 5);
    set_exp(1, 2, 3, 4); recv_vec("t1", 0);

    // saturation vs wrap
    for (int k = 0; k < 16; k++) amat[k] = -128;
    pulse_load(); send_A();
    xv = '{-128, -128, -128, -128}; send_x();
    ys = '{32767, 32767, 32767, 32767}; yw = '{0, 0, 0, 0};
    recv_vec("t2a", 0);
    for (int k = 0; k < 16; k++) amat[k] = 127;
    pulse_load(); send_A(); send_x();
    ys = '{-32768, -32768, -32768, -32768}; yw = '{512, 512, 512, 512};
    recv_vec("t2b", 0);

    // output stall on y[1]
    for (int k = 0; k < 16; k++) amat[k] = k / 4 + 1;
    pulse_load(); send_A();
    xv = '{1, 1, 1, 1}; send_x();
    set_exp(4, 8, 12, 16);
    n = 0;
    while (bus_s.m_valid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    chk("t3_y0", 32'(bus_s.m_data), 4);
    chk("t3_y0_last", 32'(bus_s.m_last), 0);
    @(posedge clk); #1;
    tb_m_ready = 1'b0;
    repeat (5) begin
      chk("t3_stall_valid", 32'(bus_s.m_valid), 1);
      chk("t3_stall_data", 32'(bus_s.m_data), 8);
      chk("t3_stall_sready", 32'(bus_s.s_ready), 0);
      @(posedge clk); #1;
    end
    recv_vec("t3", 1);

    // matrix persists across vectors
    for (int k = 0; k < 16; k++) amat[k] = ((k % 2) == 1) ? -(k + 1) : (k + 1);
    pulse_load(); send_A();
    xv = '{1, 0, 0, 0}; send_x();
    set_exp(1, 5, 9, 13); recv_vec("t4a", 0);
    chk("t4_mat_mid", 32'(mat_s), 1);
    xv = '{0, 0, 0, 1}; send_x();
    set_exp(-4, -8, -12, -16); recv_vec("t4b", 0);
    chk("t4_mat_end", 32'(mat_s), 1);

    // illegal load during OUT, legal abort in LOAD_X
    xv = '{1, 2, 3, 4};
    tb_m_ready = 1'b0;
    send_x();
    n = 0;
    while (bus_s.m_valid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    chk("t6_err_pre", 32'(err_s), 0);
    pulse_load();
    chk("t6_err", 32'(err_s), 1);
    chk("t6_still_out", 32'(bus_s.m_valid), 1);
    set_exp(-10, -18, -26, -34); recv_vec("t6a", 0);
    send_elem(9); send_elem(9);
    pulse_load();
    chk("t6_mat_cleared", 32'(mat_s), 0);
    chk("t6_err_kept", 32'(err_s), 1);
    chk("t6_in_load_a", 32'(bus_s.s_ready), 1);
    for (int k = 0; k < 16; k++) amat[k] = (k % 5 == 0) ? 1 : 0;
    send_A();
    chk("t6_mat_reload", 32'(mat_s), 1);
    xv = '{5, 6, 7, 8}; send_x();
    set_exp(5, 6, 7, 8); recv_vec("t6b", 0);

    // reset while a result is presented
    xv = '{1, 2, 3, 4};
    tb_m_ready = 1'b0;
    send_x();
    n = 0;
    while (bus_s.m_valid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    reset_n = 1'b0;
    #1;
    chk("t5_out_rst_valid", 32'(bus_s.m_valid), 0);
    chk("t5_out_rst_mat", 32'(mat_s), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // reset during COMPUTE
    pulse_load(); send_A(); send_x();
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("t5_cmp_rst_valid", 32'(bus_s.m_valid), 0);
    chk("t5_cmp_rst_mat", 32'(mat_s), 0);
    chk("t5_cmp_rst_sready", 32'(bus_s.s_ready), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    tb_m_ready = 1'b1;
    cnt = 0;
    repeat (20) begin
      if (bus_s.m_valid !== 1'b0 || bus_s.s_ready !== 1'b0) cnt++;
      @(posedge clk); #1;
    end
    chk("t5_quiet_after_rst", cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
